// File: rtl/mesi_snoop_pkg.sv
// Shared encodings, FSM state type and address-split helpers for the
// per-CPU MESI coherence-bus snooper.
package mesi_snoop_pkg;

    typedef enum logic [2:0] {
        CBUS_NOP      = 3'd0,
        CBUS_WR_SNOOP = 3'd1,
        CBUS_RD_SNOOP = 3'd2,
        CBUS_EN_WR    = 3'd3,
        CBUS_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [2:0] {
        MBUS_NOP = 3'd0,
        MBUS_WR  = 3'd1,
        MBUS_RD  = 3'd2
    } mbus_cmd_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WB,
        ST_FILL,
        ST_ACK
    } fsm_state_e;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int addr_w, input int lines);
        return addr_w - $clog2(lines);
    endfunction

endpackage

// File: rtl/mesi_line_store.sv
// Direct-mapped tag/data/MESI-state arrays: one combinational read port,
// one synchronous write port, asynchronous clear.
module mesi_line_store
    import mesi_snoop_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 30,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [DATA_W-1:0]   o_rd_data,
    output mesi_e               o_rd_state,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [TAG_W-1:0]    i_wr_tag,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  mesi_e               i_wr_state,
    output logic [2*LINES-1:0]  o_line_state
);

    logic [TAG_W-1:0]  r_tag   [LINES];
    logic [DATA_W-1:0] r_data  [LINES];
    mesi_e             r_state [LINES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
                r_state[i] <= MESI_I;
            end
        end else if (i_wr_en) begin
            r_tag[i_wr_idx]   <= i_wr_tag;
            r_data[i_wr_idx]  <= i_wr_data;
            r_state[i_wr_idx] <= i_wr_state;
        end
    end

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
    assign o_rd_state = r_state[i_rd_idx];

    always_comb begin
        o_line_state = '0;
        for (int unsigned k = 0; k < LINES; k++) begin
            o_line_state[2*k +: 2] = r_state[k];
        end
    end

endmodule

// File: rtl/mesi_cbus_snooper.sv
// Per-CPU coherence-bus responder: services mesi_isc snoop/enable commands,
// writes back Modified lines over the main bus and arbitrates local writes.
module mesi_cbus_snooper
    import mesi_snoop_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int LINES          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    output logic [DATA_WIDTH-1:0]     mbus_data_o,
    input  logic [DATA_WIDTH-1:0]     mbus_data_i,
    input  logic                      mbus_ack_i,
    input  logic                      lcl_wr_i,
    input  logic [ADDR_WIDTH-1:0]     lcl_addr_i,
    input  logic [DATA_WIDTH-1:0]     lcl_data_i,
    output logic                      lcl_ack_o,
    output logic [2*LINES-1:0]        line_state_o
);

    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(ADDR_WIDTH, LINES);

    localparam logic [CBUS_CMD_WIDTH-1:0] C_NOP = CBUS_CMD_WIDTH'(CBUS_NOP);
    localparam logic [CBUS_CMD_WIDTH-1:0] C_WRS = CBUS_CMD_WIDTH'(CBUS_WR_SNOOP);
    localparam logic [CBUS_CMD_WIDTH-1:0] C_RDS = CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
    localparam logic [CBUS_CMD_WIDTH-1:0] C_ENW = CBUS_CMD_WIDTH'(CBUS_EN_WR);
    localparam logic [CBUS_CMD_WIDTH-1:0] C_ENR = CBUS_CMD_WIDTH'(CBUS_EN_RD);
    localparam logic [MBUS_CMD_WIDTH-1:0] M_NOP = MBUS_CMD_WIDTH'(MBUS_NOP);
    localparam logic [MBUS_CMD_WIDTH-1:0] M_WR  = MBUS_CMD_WIDTH'(MBUS_WR);
    localparam logic [MBUS_CMD_WIDTH-1:0] M_RD  = MBUS_CMD_WIDTH'(MBUS_RD);

    fsm_state_e                r_state, w_next;
    logic [CBUS_CMD_WIDTH-1:0] r_cmd;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [MBUS_CMD_WIDTH-1:0] r_mbus_cmd, w_mbus_cmd_nx;
    logic [ADDR_WIDTH-1:0]     r_mbus_addr, w_mbus_addr_nx;
    logic [DATA_WIDTH-1:0]     r_mbus_data, w_mbus_data_nx;
    logic                      r_cbus_ack;
    logic                      r_lcl_ack, w_lcl_ack_nx;
    logic                      r_ignore;
    logic                      w_latch;

    logic [ADDR_WIDTH-1:0]     w_lookup_addr;
    logic [IDX_W-1:0]          w_idx;
    logic [TAG_W-1:0]          w_lk_tag;
    logic [TAG_W-1:0]          w_rd_tag;
    logic [DATA_WIDTH-1:0]     w_rd_data;
    mesi_e                     w_rd_state;
    logic                      w_hit;

    logic                      w_wr_en;
    logic [TAG_W-1:0]          w_wr_tag;
    logic [DATA_WIDTH-1:0]     w_wr_data;
    mesi_e                     w_wr_state;

    // The single read port serves local-write lookup in IDLE, the latched command otherwise.
    assign w_lookup_addr = (r_state == ST_IDLE) ? lcl_addr_i : r_addr;
    assign w_idx         = w_lookup_addr[IDX_W-1:0];
    assign w_lk_tag      = w_lookup_addr[ADDR_WIDTH-1:IDX_W];
    assign w_hit         = (w_rd_tag == w_lk_tag) && (w_rd_state != MESI_I);

    mesi_line_store #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WIDTH)
    ) u_store (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rd_idx     (w_idx),
        .o_rd_tag     (w_rd_tag),
        .o_rd_data    (w_rd_data),
        .o_rd_state   (w_rd_state),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_idx),
        .i_wr_tag     (w_wr_tag),
        .i_wr_data    (w_wr_data),
        .i_wr_state   (w_wr_state),
        .o_line_state (line_state_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_mbus_cmd  <= '0;
            r_mbus_addr <= '0;
            r_mbus_data <= '0;
            r_cbus_ack  <= 1'b0;
            r_lcl_ack   <= 1'b0;
            r_ignore    <= 1'b0;
        end else begin
            r_state     <= w_next;
            if (w_latch) begin
                r_cmd  <= cbus_cmd_i;
                r_addr <= cbus_addr_i;
            end
            r_mbus_cmd  <= w_mbus_cmd_nx;
            r_mbus_addr <= w_mbus_addr_nx;
            r_mbus_data <= w_mbus_data_nx;
            r_cbus_ack  <= (w_next == ST_ACK);
            r_lcl_ack   <= w_lcl_ack_nx;
            r_ignore    <= (r_state == ST_ACK);
        end
    end

    always_comb begin
        w_next         = r_state;
        w_latch        = 1'b0;
        w_lcl_ack_nx   = 1'b0;
        w_mbus_cmd_nx  = r_mbus_cmd;
        w_mbus_addr_nx = r_mbus_addr;
        w_mbus_data_nx = r_mbus_data;
        w_wr_en        = 1'b0;
        w_wr_tag       = w_rd_tag;
        w_wr_data      = w_rd_data;
        w_wr_state     = w_rd_state;

        unique case (r_state)
            ST_IDLE: begin
                if (!r_ignore && cbus_cmd_i != C_NOP) begin
                    w_latch = 1'b1;
                    w_next  = ST_DECODE;
                end else if (cbus_cmd_i == C_NOP && lcl_wr_i && w_hit &&
                             (w_rd_state == MESI_E || w_rd_state == MESI_M)) begin
                    w_wr_en      = 1'b1;
                    w_wr_data    = lcl_data_i;
                    w_wr_state   = MESI_M;
                    w_lcl_ack_nx = 1'b1;
                end
            end
            ST_DECODE: begin
                w_next = ST_ACK;
                if (r_cmd == C_WRS || r_cmd == C_RDS) begin
                    if (w_hit && w_rd_state == MESI_M) begin
                        w_next = ST_WB;
                    end else if (w_hit) begin
                        w_wr_en    = 1'b1;
                        w_wr_state = (r_cmd == C_WRS) ? MESI_I : MESI_S;
                    end
                end else if (r_cmd == C_ENW || r_cmd == C_ENR) begin
                    if (w_hit) begin
                        if (r_cmd == C_ENW) begin
                            w_wr_en    = 1'b1;
                            w_wr_state = MESI_M;
                        end
                    end else if (w_rd_state == MESI_M) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_FILL;
                    end
                end
                if (w_next == ST_WB) begin
                    w_mbus_cmd_nx  = M_WR;
                    w_mbus_addr_nx = {w_rd_tag, w_idx};
                    w_mbus_data_nx = w_rd_data;
                end else if (w_next == ST_FILL) begin
                    w_mbus_cmd_nx  = M_RD;
                    w_mbus_addr_nx = r_addr;
                end
            end
            ST_WB: begin
                if (mbus_ack_i) begin
                    w_wr_en    = 1'b1;
                    w_wr_state = (r_cmd == C_RDS) ? MESI_S : MESI_I;
                    // Victim write-back chains straight into the fill without a NOP gap.
                    if (r_cmd == C_ENW || r_cmd == C_ENR) begin
                        w_next         = ST_FILL;
                        w_mbus_cmd_nx  = M_RD;
                        w_mbus_addr_nx = r_addr;
                    end else begin
                        w_next        = ST_ACK;
                        w_mbus_cmd_nx = M_NOP;
                    end
                end
            end
            ST_FILL: begin
                if (mbus_ack_i) begin
                    w_wr_en       = 1'b1;
                    w_wr_tag      = r_addr[ADDR_WIDTH-1:IDX_W];
                    w_wr_data     = mbus_data_i;
                    w_wr_state    = (r_cmd == C_ENW) ? MESI_M : MESI_S;
                    w_next        = ST_ACK;
                    w_mbus_cmd_nx = M_NOP;
                end
            end
            ST_ACK: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign cbus_ack_o  = r_cbus_ack;
    assign lcl_ack_o   = r_lcl_ack;
    assign mbus_cmd_o  = r_mbus_cmd;
    assign mbus_addr_o = r_mbus_addr;
    assign mbus_data_o = r_mbus_data;

endmodule

// File: tb/tb_mesi_cbus_snooper.sv
// Scoreboard bench for mesi_cbus_snooper: directed commands push expected bus
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_mesi_cbus_snooper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cbus_cmd_i = '0;
    logic [31:0] cbus_addr_i = '0;
    logic        cbus_ack_o;
    logic [2:0]  mbus_cmd_o;
    logic [31:0] mbus_addr_o;
    logic [31:0] mbus_data_o;
    logic [31:0] mbus_data_i = '0;
    logic        mbus_ack_i = 1'b0;
    logic        lcl_wr_i = 1'b0;
    logic [31:0] lcl_addr_i = '0;
    logic [31:0] lcl_data_i = '0;
    logic        lcl_ack_o;
    logic [7:0]  line_state_o;

    mesi_cbus_snooper #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .CBUS_CMD_WIDTH (3),
        .MBUS_CMD_WIDTH (3),
        .LINES          (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cbus_cmd_i   (cbus_cmd_i),
        .cbus_addr_i  (cbus_addr_i),
        .cbus_ack_o   (cbus_ack_o),
        .mbus_cmd_o   (mbus_cmd_o),
        .mbus_addr_o  (mbus_addr_o),
        .mbus_data_o  (mbus_data_o),
        .mbus_data_i  (mbus_data_i),
        .mbus_ack_i   (mbus_ack_i),
        .lcl_wr_i     (lcl_wr_i),
        .lcl_addr_i   (lcl_addr_i),
        .lcl_data_i   (lcl_data_i),
        .lcl_ack_o    (lcl_ack_o),
        .line_state_o (line_state_o)
    );

    always #5 clk = ~clk;

    localparam int EV_MBUS = 0;
    localparam int EV_CACK = 1;
    localparam int EV_LACK = 2;

    typedef struct {
        int          kind;
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_data;
        int          lat;
    } ev_t;

    ev_t         q_exp[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          mb_wait = 0;
    int          wcnt = 0;
    logic [31:0] mb_fill = '0;
    logic [2:0]  prev_mcmd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input logic [2:0] cmd, input logic [31:0] addr,
                        input logic [31:0] data, input bit chk_data, input int lat);
        ev_t e;
        e.kind = kind; e.cmd = cmd; e.addr = addr; e.data = data;
        e.chk_data = chk_data; e.lat = lat;
        q_exp.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input logic [2:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data);
        ev_t e;
        bit  ok;
        checks++;
        if (q_exp.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind=%0d cmd=%0d addr=%h data=%h cycle=%0d",
                     kind, cmd, addr, data, cyc - t0);
            return;
        end
        e  = q_exp.pop_front();
        ok = (e.kind == kind);
        if (kind == EV_MBUS)
            ok = ok && (e.cmd == cmd) && (e.addr == addr) && (!e.chk_data || e.data == data);
        if (e.lat >= 0)
            ok = ok && ((cyc - t0) == e.lat);
        if (!ok) begin
            failures++;
            $display("FAIL event: got kind=%0d cmd=%0d addr=%h data=%h lat=%0d expected kind=%0d cmd=%0d addr=%h data=%h lat=%0d",
                     kind, cmd, addr, data, cyc - t0, e.kind, e.cmd, e.addr, e.data, e.lat);
        end
    endtask

    // Monitor: reports each new mbus command, every cbus ack and every local ack.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mbus_cmd_o != 3'd0 && mbus_cmd_o != prev_mcmd)
                    check_ev(EV_MBUS, mbus_cmd_o, mbus_addr_o, mbus_data_o);
                if (cbus_ack_o) check_ev(EV_CACK, 3'd0, '0, '0);
                if (lcl_ack_o)  check_ev(EV_LACK, 3'd0, '0, '0);
            end
            prev_mcmd = mbus_cmd_o;
        end
    end

    // Main-bus responder: acks after mb_wait idle cycles, supplying mb_fill.
    initial begin
        forever begin
            @(negedge clk);
            if (mbus_cmd_o != 3'd0 && !mbus_ack_i) begin
                if (wcnt >= mb_wait) begin
                    mbus_ack_i  = 1'b1;
                    mbus_data_i = mb_fill;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                mbus_ack_i = 1'b0;
                if (mbus_cmd_o == 3'd0) wcnt = 0;
            end
        end
    end

    task automatic do_cmd(input logic [2:0] c, input logic [31:0] a, input bit lw,
                          input logic [31:0] la, input logic [31:0] ld);
        bit got;
        @(posedge clk); #1;
        cbus_cmd_i = c; cbus_addr_i = a; t0 = cyc;
        lcl_wr_i = lw; lcl_addr_i = la; lcl_data_i = ld;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1 lcl_wr_i = 1'b0;
            @(negedge clk);
            if (cbus_ack_o) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL cbus_ack_timeout: cmd=%0d addr=%h no ack", c, a);
        end
        @(posedge clk); #1 cbus_cmd_i = 3'd0;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [31:0] a);
        do_cmd(c, a, 1'b0, '0, '0);
    endtask

    task automatic lcl_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        lcl_wr_i = 1'b1; lcl_addr_i = a; lcl_data_i = d; t0 = cyc;
        @(posedge clk); #1 lcl_wr_i = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_states", 32'(line_state_o), 32'h0);
        chk("reset_mbus_cmd", 32'(mbus_cmd_o), 32'h0);
        chk("reset_mbus_addr", mbus_addr_o, 32'h0);
        chk("reset_acks", {30'd0, cbus_ack_o, lcl_ack_o}, 32'h0);
        rst_n = 1'b1;

        // Line 1 becomes M, tag 1, data DEADBEEF
        mb_wait = 0; mb_fill = 32'hDEADBEEF;
        push(EV_MBUS, 3'd2, 32'h5, '0, 1'b0, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, -1);
        cmd(3'd3, 32'h5);
        chk("enwr_fill_state", 32'(line_state_o), 32'h0C);

        // RD_SNOOP on M with 3 wait cycles
        mb_wait = 3;
        push(EV_MBUS, 3'd1, 32'h5, 32'hDEADBEEF, 1'b1, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 6);
        cmd(3'd2, 32'h5);
        chk("rdsnoop_m_to_s", 32'(line_state_o), 32'h04);
        mb_wait = 0;

        // WR_SNOOP tag miss
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 2);
        cmd(3'd1, 32'h9);
        chk("wrsnoop_miss_state", 32'(line_state_o), 32'h04);

        // Line 2 filled S, then WR_SNOOP hit on a clean line invalidates it
        mb_fill = 32'h00000606;
        push(EV_MBUS, 3'd2, 32'h6, '0, 1'b0, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, -1);
        cmd(3'd4, 32'h6);
        chk("enrd_fill_s", 32'(line_state_o), 32'h14);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 2);
        cmd(3'd1, 32'h6);
        chk("wrsnoop_clean_inv", 32'(line_state_o), 32'h04);

        // EN_WR miss with M victim on line 0
        mb_fill = 32'hAAAA5555;
        push(EV_MBUS, 3'd2, 32'hC, '0, 1'b0, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, -1);
        cmd(3'd3, 32'hC);
        chk("line0_m_tag3", 32'(line_state_o), 32'h07);
        mb_fill = 32'h12345678;
        push(EV_MBUS, 3'd1, 32'hC, 32'hAAAA5555, 1'b1, 2);
        push(EV_MBUS, 3'd2, 32'h4, '0, 1'b0, -1);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, -1);
        cmd(3'd3, 32'h4);
        chk("victim_refill_m", 32'(line_state_o), 32'h07);
        push(EV_MBUS, 3'd1, 32'h4, 32'h12345678, 1'b1, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 3);
        cmd(3'd2, 32'h4);
        chk("line0_now_s", 32'(line_state_o), 32'h05);

        // Local write arbitration on line 3
        mb_fill = 32'h77777777;
        push(EV_MBUS, 3'd2, 32'h7, '0, 1'b0, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, -1);
        cmd(3'd3, 32'h7);
        chk("line3_m", 32'(line_state_o), 32'hC5);
        push(EV_MBUS, 3'd1, 32'h7, 32'h77777777, 1'b1, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 3);
        do_cmd(3'd2, 32'h7, 1'b1, 32'h7, 32'hBBBB0000);
        chk("lcl_lost_arb_state", 32'(line_state_o), 32'h45);
        lcl_write(32'h7, 32'hCCCC0000);
        chk("lcl_drop_on_s", 32'(line_state_o), 32'h45);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 2);
        cmd(3'd3, 32'h7);
        chk("enwr_hit_s_to_m", 32'(line_state_o), 32'hC5);
        push(EV_LACK, 3'd0, '0, '0, 1'b0, 1);
        lcl_write(32'h7, 32'hBBBB0000);
        push(EV_MBUS, 3'd1, 32'h7, 32'hBBBB0000, 1'b1, 2);
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 3);
        cmd(3'd2, 32'h7);
        chk("lcl_data_written", 32'(line_state_o), 32'h45);

        // Unknown command code
        push(EV_CACK, 3'd0, '0, '0, 1'b0, 2);
        cmd(3'd6, 32'h5);
        chk("unknown_cmd_state", 32'(line_state_o), 32'h45);

        // Reset while a fill is pending
        mb_wait = 1000;
        push(EV_MBUS, 3'd2, 32'h9, '0, 1'b0, 2);
        @(posedge clk); #1;
        cbus_cmd_i = 3'd4; cbus_addr_i = 32'h9; t0 = cyc;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mbus_cmd_o == 3'd2) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL fill_start_timeout: mbus_cmd=%0d expected 2", mbus_cmd_o);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_mbus_nop", 32'(mbus_cmd_o), 32'h0);
        chk("rst_async_states", 32'(line_state_o), 32'h0);
        cbus_cmd_i = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; mb_wait = 0;
        repeat (8) @(negedge clk);
        chk("post_rst_mbus", 32'(mbus_cmd_o), 32'h0);
        chk("post_rst_states", 32'(line_state_o), 32'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d outstanding expected 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
